// File: rtl/interrupt_judge.sv
// interrupt_judge: machine-level interrupt arbiter for the fetch stage.
// Combines raw interrupt lines with mstatus/mie/mip, the timer compare and
// the privilege mode, and registers a take-interrupt flag plus the mcause
// value. Priority is external > software > timer.
module interrupt_judge (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  priviledgeMode,
   input  logic        trint,
   input  logic        swint,
   input  logic        exint,
   input  logic [63:0] mstatus,
   input  logic [63:0] mtimecmp,
   input  logic [63:0] mcycle,
   input  logic [63:0] mip,
   input  logic [63:0] mie,
   output logic        intEn,
   output logic [63:0] exception
);

   localparam logic [63:0] CAUSE_EXT = 64'h8000_0000_0000_000B;
   localparam logic [63:0] CAUSE_SW  = 64'h8000_0000_0000_0003;
   localparam logic [63:0] CAUSE_TM  = 64'h8000_0000_0000_0007;

   logic        sw_p, tm_p, ex_p;
   logic        sw_e, tm_e, ex_e;
   logic        glob_en;
   logic        int_en_d, int_en_q;
   logic [63:0] cause_d, cause_q;

   // Only MIE, MSIP/MTIP/MEIP and MSIE/MTIE/MEIE matter; the rest is ignored.
   logic        unused_bits;
   assign unused_bits = ^{mstatus[63:4], mstatus[2:0],
                          mip[63:12], mip[10:8], mip[6:4], mip[2:0],
                          mie[63:12], mie[10:8], mie[6:4], mie[2:0]};

   // Pending/enable terms, global gating and fixed-priority cause selection.
   always_comb begin
      sw_p = swint | mip[3];
      tm_p = trint | mip[7] | (mcycle >= mtimecmp);
      ex_p = exint | mip[11];

      sw_e = sw_p & mie[3];
      tm_e = tm_p & mie[7];
      ex_e = ex_p & mie[11];

      // U and S are always interruptible by M-level; reserved mode 2 acts as M.
      glob_en = (priviledgeMode[1] == 1'b0) ? 1'b1 : mstatus[3];

      int_en_d = glob_en & (ex_e | sw_e | tm_e);
      cause_d  = '0;
      if (int_en_d) begin
         if (ex_e)      cause_d = CAUSE_EXT;
         else if (sw_e) cause_d = CAUSE_SW;
         else           cause_d = CAUSE_TM;
      end
   end

   // Register the decision; asynchronous reset clears both outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_en_q <= 1'b0;
         cause_q  <= '0;
      end else begin
         int_en_q <= int_en_d;
         cause_q  <= cause_d;
      end
   end

   assign intEn     = int_en_q;
   assign exception = cause_q;

endmodule

// File: tb/tb_interrupt_judge.sv
// tb_interrupt_judge: directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_interrupt_judge;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  priviledgeMode;
   logic        trint, swint, exint;
   logic [63:0] mstatus, mtimecmp, mcycle, mip, mie;
   logic        intEn;
   logic [63:0] exception;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   localparam logic [63:0] C_EXT = 64'h8000_0000_0000_000B;
   localparam logic [63:0] C_SW  = 64'h8000_0000_0000_0003;
   localparam logic [63:0] C_TM  = 64'h8000_0000_0000_0007;

   interrupt_judge dut (
      .clk(clk), .rst(rst), .priviledgeMode(priviledgeMode),
      .trint(trint), .swint(swint), .exint(exint),
      .mstatus(mstatus), .mtimecmp(mtimecmp), .mcycle(mcycle),
      .mip(mip), .mie(mie), .intEn(intEn), .exception(exception)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and land 1ns after it, away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic en, input logic [63:0] cause);
      check({tag, ".intEn"}, {63'd0, intEn}, {63'd0, en});
      check({tag, ".exc"}, exception, cause);
   endtask

   initial begin
      rst = 1'b1;
      priviledgeMode = 2'd0;
      trint = 1'b0; swint = 1'b0; exint = 1'b1;
      mstatus = '0; mtimecmp = '1; mcycle = '0; mip = '0;
      mie = 64'h800;

      // Held in reset with an enabled, pending external interrupt.
      step(); step();
      expect_out("reset_hold", 1'b0, '0);
      rst = 1'b0;
      check("pre_edge_after_release", {63'd0, intEn}, 64'd0);
      step();
      expect_out("after_release", 1'b1, C_EXT);

      // Asynchronous reset mid-operation.
      #2 rst = 1'b1;
      #1 expect_out("async_reset", 1'b0, '0);
      step();
      rst = 1'b0;
      step();
      expect_out("post_async_reset", 1'b1, C_EXT);

      // Global enable gating in M-mode with timer at boundary.
      exint = 1'b0; mie = 64'h80; priviledgeMode = 2'd3;
      mcycle = 64'd100; mtimecmp = 64'd100; mstatus = '0;
      step();
      expect_out("m_mie0", 1'b0, '0);
      mstatus = 64'h8;
      #1 check("latency_hold", {63'd0, intEn}, 64'd0);
      step();
      expect_out("m_mie1", 1'b1, C_TM);

      // Timer boundary in U-mode.
      priviledgeMode = 2'd0; mstatus = '0;
      mcycle = 64'd99;
      step();
      expect_out("tm_below", 1'b0, '0);
      mcycle = 64'd100;
      step();
      expect_out("tm_equal", 1'b1, C_TM);
      mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; mcycle = 64'd5;
      step();
      expect_out("tm_unsigned", 1'b0, '0);
      mtimecmp = '0;
      step();
      expect_out("tm_cmp_zero", 1'b1, C_TM);
      mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;

      // Priority external > software > timer.
      mie = 64'h888; swint = 1'b1; trint = 1'b1; exint = 1'b1;
      step();
      expect_out("prio_all", 1'b1, C_EXT);
      exint = 1'b0;
      step();
      expect_out("prio_sw_tm", 1'b1, C_SW);
      swint = 1'b0;
      step();
      expect_out("prio_tm", 1'b1, C_TM);
      trint = 1'b0;
      step();
      expect_out("prio_none", 1'b0, '0);

      // mip path and per-source masking in S-mode.
      priviledgeMode = 2'd1; mip = 64'h8; mie = '0;
      step();
      expect_out("mip_masked", 1'b0, '0);
      mie = 64'h8;
      step();
      expect_out("mip_sw", 1'b1, C_SW);
      mip = 64'h80; mie = 64'h80;
      step();
      expect_out("mip_tm", 1'b1, C_TM);
      mip = 64'h800; mie = 64'h880;
      step();
      expect_out("mip_ext", 1'b1, C_EXT);

      // S/U-level bits are ignored.
      mip = '1; mie = 64'h222;
      step();
      expect_out("slevel_ignored", 1'b0, '0);
      mip = '0;

      // Reserved mode 2 is treated as M.
      priviledgeMode = 2'd2; mstatus = '0; exint = 1'b1; mie = 64'h800;
      step();
      expect_out("mode2_gated", 1'b0, '0);
      mstatus = 64'h8;
      step();
      expect_out("mode2_enabled", 1'b1, C_EXT);
      mstatus = 64'hFFFF_FFFF_FFFF_FFF7;
      step();
      expect_out("mode2_other_bits", 1'b0, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
